friscv_cache_nway_blocks: RTL and testbench

//  N-way set-associative cache block storage, successor of the direct-mapped

---
 rtl/friscv_cache_nway_blocks.sv | 198 +++++++++++++++++++
 tb/tb_friscv_cache_nway_blocks.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/friscv_cache_nway_blocks.sv
// N-way set-associative cache block storage: tag/valid/data arrays,
// tree pseudo-LRU replacement and a set-sweep FSM for boot init and flush.
module friscv_cache_nway_blocks #(
  parameter int WLEN          = 32,
  parameter int ADDR_W        = 32,
  parameter int CACHE_BLOCK_W = 128,
  parameter int CACHE_DEPTH   = 128,
  parameter int CACHE_WAYS    = 2
) (
  input  logic                     aclk,
  input  logic                     arst,
  output logic                     ready,
  input  logic                     flush_req,
  output logic                     flush_ack,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [CACHE_BLOCK_W-1:0] wdata,
  input  logic                     ren,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [WLEN-1:0]          rdata,
  output logic                     hit,
  output logic                     miss
);

  // state   | meaning
  // S_INIT  | boot sweep: clear valid + PLRU of set[cnt], one set per cycle
  // S_IDLE  | serving lookups and fills
  // S_FLUSH | flush sweep, same as S_INIT
  // S_ACK   | one-cycle flush_ack pulse, still serving

  localparam int OFF_W   = $clog2(CACHE_BLOCK_W / 8);
  localparam int IDX_W   = $clog2(CACHE_DEPTH);
  localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
  localparam int WSEL_LO = $clog2(WLEN / 8);
  localparam int LVLS    = $clog2(CACHE_WAYS);
  localparam int WAY_W   = (LVLS > 0) ? LVLS : 1;
  localparam int PLRU_W  = (CACHE_WAYS > 1) ? CACHE_WAYS - 1 : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_FLUSH, S_ACK} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             sweep;

  logic [CACHE_BLOCK_W-1:0] data_mem  [CACHE_DEPTH][CACHE_WAYS];
  logic [TAG_W-1:0]         tag_mem   [CACHE_DEPTH][CACHE_WAYS];
  logic [CACHE_WAYS-1:0]    valid_mem [CACHE_DEPTH];
  logic [PLRU_W-1:0]        plru_mem  [CACHE_DEPTH];

  logic [IDX_W-1:0]         rd_idx, wr_idx;
  logic [TAG_W-1:0]         rd_tag, wr_tag;
  logic [OFF_W-1:0]         word_sel;
  logic                     rd_go, wr_go, rd_hit, inv_found;
  int                       rd_cnt;
  logic [WAY_W-1:0]         rd_way, fill_way;
  logic [CACHE_BLOCK_W-1:0] rd_line, rd_shift;

  // Victim: the way whose every ancestor node points towards it.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] pl);
    logic              ok;
    logic [PLRU_W-1:0] sh;
    plru_victim = '0;
    for (int w = 0; w < CACHE_WAYS; w++) begin
      ok = 1'b1;
      for (int l = 0; l < LVLS; l++) begin
        sh = pl >> ((1 << l) - 1 + (w >> (LVLS - l)));
        ok = ok & (sh[0] == 1'((w >> (LVLS - l - 1)) & 1));
      end
      if (ok) plru_victim = WAY_W'(w);
    end
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] pl,
                                                   input logic [WAY_W-1:0]  way);
    int   n;
    logic d;
    plru_touch = pl;
    for (int l = 0; l < LVLS; l++) begin
      n = (1 << l) - 1 + (int'(way) >> (LVLS - l));
      d = 1'((int'(way) >> (LVLS - l - 1)) & 1);
      plru_touch = (plru_touch & ~(PLRU_W'(1) << n)) | (PLRU_W'(~d) << n);
    end
  endfunction

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == IDX_W'(CACHE_DEPTH - 1)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        cnt_nxt = '0;
        if (flush_req) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == IDX_W'(CACHE_DEPTH - 1)) state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    ready     = (state == S_IDLE) || (state == S_ACK);
    flush_ack = (state == S_ACK);
    sweep     = (state == S_INIT) || (state == S_FLUSH);
  end

  assign rd_go    = ren & ready;
  assign wr_go    = wen & ready;
  assign rd_idx   = raddr[OFF_W +: IDX_W];
  assign rd_tag   = raddr[ADDR_W-1 -: TAG_W];
  assign wr_idx   = waddr[OFF_W +: IDX_W];
  assign wr_tag   = waddr[ADDR_W-1 -: TAG_W];
  assign word_sel = raddr[OFF_W-1:0] >> WSEL_LO;

  always_comb begin
    rd_cnt  = 0;
    rd_way  = '0;
    rd_line = '0;
    for (int w = 0; w < CACHE_WAYS; w++) begin
      if (valid_mem[rd_idx][w] && (tag_mem[rd_idx][w] == rd_tag)) begin
        rd_cnt  = rd_cnt + 1;
        rd_way  = WAY_W'(w);
        rd_line = data_mem[rd_idx][w];
      end
    end
    rd_hit   = (rd_cnt == 1);
    rd_shift = rd_line >> (int'(word_sel) * WLEN);
  end

  // Priority: same-tag way, then lowest invalid way, then PLRU victim.
  always_comb begin
    fill_way  = plru_victim(plru_mem[wr_idx]);
    inv_found = 1'b0;
    for (int w = 0; w < CACHE_WAYS; w++) begin
      if (!inv_found && !valid_mem[wr_idx][w]) begin
        fill_way  = WAY_W'(w);
        inv_found = 1'b1;
      end
    end
    for (int w = 0; w < CACHE_WAYS; w++) begin
      if (valid_mem[wr_idx][w] && (tag_mem[wr_idx][w] == wr_tag)) fill_way = WAY_W'(w);
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      hit   <= 1'b0;
      miss  <= 1'b0;
      rdata <= '0;
    end else begin
      hit   <= rd_go & rd_hit;
      miss  <= rd_go & ~rd_hit;
      rdata <= (rd_go && rd_hit) ? rd_shift[WLEN-1:0] : '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_go) begin
      data_mem[wr_idx][fill_way] <= wdata;
      tag_mem[wr_idx][fill_way]  <= wr_tag;
    end
  end

  always_ff @(posedge aclk) begin
    if (sweep) valid_mem[cnt] <= '0;
    else if (wr_go) valid_mem[wr_idx][fill_way] <= 1'b1;
  end

  // A fill to the same set wins over the read-hit PLRU update.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      for (int s = 0; s < CACHE_DEPTH; s++) plru_mem[s] <= '0;
    end else if (sweep) begin
      plru_mem[cnt] <= '0;
    end else begin
      if (rd_go && rd_hit && !(wr_go && (wr_idx == rd_idx)))
        plru_mem[rd_idx] <= plru_touch(plru_mem[rd_idx], rd_way);
      if (wr_go)
        plru_mem[wr_idx] <= plru_touch(plru_mem[wr_idx], fill_way);
    end
  end

endmodule

// File: tb/tb_friscv_cache_nway_blocks.sv
// Directed bench for friscv_cache_nway_blocks with 4 sets x 2 ways, 16-byte lines.
module tb_friscv_cache_nway_blocks;

  logic         aclk, arst;
  logic         ready, flush_req, flush_ack;
  logic         wen, ren;
  logic [31:0]  waddr, raddr;
  logic [127:0] wdata;
  logic [31:0]  rdata;
  logic         hit, miss;

  int n_tests = 0;
  int n_fail  = 0;

  friscv_cache_nway_blocks #(
    .WLEN(32), .ADDR_W(32), .CACHE_BLOCK_W(128), .CACHE_DEPTH(4), .CACHE_WAYS(2)
  ) dut (
    .aclk(aclk), .arst(arst), .ready(ready), .flush_req(flush_req), .flush_ack(flush_ack),
    .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren), .raddr(raddr),
    .rdata(rdata), .hit(hit), .miss(miss)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic fill(input logic [31:0] addr, input logic [127:0] data);
    wen = 1'b1; waddr = addr; wdata = data;
    cycle();
    wen = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] addr,
                        input logic exp_hit, input logic [31:0] exp_data);
    ren = 1'b1; raddr = addr;
    cycle();
    ren = 1'b0;
    check({tag, ".hit"},   32'(hit),  32'(exp_hit));
    check({tag, ".miss"},  32'(miss), 32'(!exp_hit));
    check({tag, ".rdata"}, rdata, exp_hit ? exp_data : 32'h0);
  endtask

  // ready must stay low for exactly 4 cycles after reset release, no ack meanwhile.
  task automatic boot_check(input string tag);
    int low;
    int acks;
    low = 0; acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (!ready) low++;
      if (flush_ack) acks++;
      cycle();
    end
    check({tag, ".ready_low"}, 32'(low), 32'd4);
    check({tag, ".no_ack"},    32'(acks), 32'd0);
    check({tag, ".ready"},     32'(ready), 32'd1);
  endtask

  initial begin
    int low, acks, stray;
    bit done;
    arst = 1'b1; flush_req = 1'b0; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;
    repeat (3) cycle();
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.ack",   32'(flush_ack), 32'd0);
    check("rst.hit",   32'(hit), 32'd0);
    check("rst.miss",  32'(miss), 32'd0);
    check("rst.rdata", rdata, 32'h0);
    arst = 1'b0;
    boot_check("boot");

    lookup("cold", 32'h0, 1'b0, 32'h0);

    fill(32'h0000, {32'h0, 32'h0, 32'hDEADBEEF, 32'h11111111});
    lookup("w1", 32'h0004, 1'b1, 32'hDEADBEEF);
    lookup("w0", 32'h0000, 1'b1, 32'h11111111);

    // Set 0: lines 0x00/0x40 fill both ways, read 0x40 makes 0x00 the victim.
    fill(32'h0040, {96'h0, 32'h40404040});
    lookup("rd40", 32'h0040, 1'b1, 32'h40404040);
    fill(32'h0080, {96'h0, 32'h80808080});
    lookup("evict00", 32'h0000, 1'b0, 32'h0);
    lookup("keep40",  32'h0040, 1'b1, 32'h40404040);
    lookup("keep80",  32'h0080, 1'b1, 32'h80808080);

    fill(32'h0040, {96'h0, 32'h4040AAAA});
    lookup("ovr80", 32'h0080, 1'b1, 32'h80808080);
    lookup("ovr40", 32'h0040, 1'b1, 32'h4040AAAA);

    // Flush with lookups held during the sweep: they must be ignored.
    flush_req = 1'b1;
    cycle();
    low = (ready == 1'b0) ? 1 : 0;
    acks = 0; stray = 0; done = 1'b0;
    ren = 1'b1; raddr = 32'h0080;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      if (hit || miss) stray++;
      if (!ready) low++;
      if (flush_ack) begin
        acks++; done = 1'b1; flush_req = 1'b0; ren = 1'b0;
      end
    end
    check("flush.ready_low", 32'(low), 32'd4);
    check("flush.ack_seen",  32'(acks), 32'd1);
    check("flush.ignored",   32'(stray), 32'd0);
    check("flush.ack_ready", 32'(ready), 32'd1);
    cycle();
    check("flush.ack_pulse", 32'(flush_ack), 32'd0);
    check("flush.idle_rdy",  32'(ready), 32'd1);
    lookup("fl00", 32'h0000, 1'b0, 32'h0);
    lookup("fl40", 32'h0040, 1'b0, 32'h0);
    lookup("fl80", 32'h0080, 1'b0, 32'h0);

    // Same-cycle read and fill: read sees the pre-write contents.
    fill(32'h0040, {96'h0, 32'h11112222});
    ren = 1'b1; raddr = 32'h0040;
    wen = 1'b1; waddr = 32'h0040; wdata = {96'h0, 32'h33334444};
    cycle();
    ren = 1'b0; wen = 1'b0;
    check("rw.hit",   32'(hit), 32'd1);
    check("rw.rdata", rdata, 32'h11112222);
    lookup("rw.after", 32'h0040, 1'b1, 32'h33334444);
    ren = 1'b1; raddr = 32'h0010;
    wen = 1'b1; waddr = 32'h0010; wdata = {96'h0, 32'h10101010};
    cycle();
    ren = 1'b0; wen = 1'b0;
    check("rwnew.miss", 32'(miss), 32'd1);
    check("rwnew.hit",  32'(hit), 32'd0);
    lookup("rwnew.after", 32'h0010, 1'b1, 32'h10101010);

    // Reset in the middle of a flush: no ack, INIT re-runs and clears lines.
    flush_req = 1'b1;
    repeat (3) cycle();
    arst = 1'b1; flush_req = 1'b0;
    #1;
    check("midrst.ready", 32'(ready), 32'd0);
    check("midrst.ack",   32'(flush_ack), 32'd0);
    cycle();
    arst = 1'b0;
    boot_check("reboot");
    lookup("reboot40", 32'h0040, 1'b0, 32'h0);
    lookup("reboot10", 32'h0010, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
